// File: rtl/riscv_lsu_dmem_ctrl.sv
// riscv_lsu_dmem_ctrl: RV32I load/store unit driving a word-wide RAM without byte enables
module riscv_lsu_dmem_ctrl #(
    parameter int AW = 7,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;
    state_t state, state_nx;
    logic [AW-1:0] a_addr;
    logic [1:0] a_lane;
    logic [2:0] a_f3;
    logic [15:0] a_wd;
    logic err, is_sw, accept;
    logic [7:0] byte_v;
    logic [15:0] half_v;
    logic [DW-1:0] ld_data, merge;
    assign req_ready = state == IDLE;
    assign accept = req_valid && req_ready;
    assign is_sw = req_we && req_funct3 == 3'd2;
    assign byte_v = ram_rdata[{a_lane, 3'b0} +: 8];
    assign half_v = ram_rdata[{a_lane[1], 4'b0} +: 16];
    assign ld_data = a_f3[1:0] == 2'd2 ? ram_rdata
                   : a_f3[1:0] == 2'd1 ? {{16{~a_f3[2] & half_v[15]}}, half_v}
                   : {{24{~a_f3[2] & byte_v[7]}}, byte_v};
    // request legality: bad funct3, misaligned halfword/word, or outside the RAM window
    always_comb begin
        err = (req_we ? req_funct3 > 3'd2 : (req_funct3[1:0] == 2'b11 || req_funct3 == 3'd6))
            || (req_funct3[1:0] == 2'd1 && req_addr[0])
            || (req_funct3[1:0] == 2'd2 && |req_addr[1:0])
            || |req_addr[31:AW+2];
    end
    // sub-word store: replace the target lane of the old word, keep the rest
    always_comb begin
        merge = ram_rdata;
        if (a_f3[0]) merge[{a_lane[1], 4'b0} +: 16] = a_wd;
        else merge[{a_lane, 3'b0} +: 8] = a_wd[7:0];
    end
    // next state and RAM strobes; strobes are killed while reset is held
    always_comb begin
        state_nx = state;
        ram_en = 1'b0;
        ram_we = 1'b0;
        ram_addr = a_addr;
        ram_wdata = merge;
        if (state == IDLE) begin
            ram_en = req_valid && !err && !rst;
            ram_we = is_sw && !rst;
            ram_addr = req_addr[AW+1:2];
            ram_wdata = req_wdata;
            if (req_valid && !err && !is_sw) state_nx = req_we ? RMW : LOAD;
        end else if (state == RMW) begin
            ram_en = !rst;
            ram_we = !rst;
            state_nx = IDLE;
        end else begin
            state_nx = IDLE;
        end
    end
    // state, holding registers and the response pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_addr <= '0;
            a_lane <= '0;
            a_f3 <= '0;
            a_wd <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
        end else begin
            state <= state_nx;
            resp_valid <= 1'b0;
            if (accept) begin
                a_addr <= req_addr[AW+1:2];
                a_lane <= req_addr[1:0];
                a_f3 <= req_funct3;
                a_wd <= req_wdata[15:0];
                if (err || is_sw) begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    resp_err <= err;
                end
            end else if (state != IDLE) begin
                resp_valid <= 1'b1;
                resp_rdata <= state == LOAD ? ld_data : '0;
                resp_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_riscv_lsu_dmem_ctrl.sv
// tb_riscv_lsu_dmem_ctrl: directed vectors against a behavioural word RAM
module tb_riscv_lsu_dmem_ctrl;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_we = 0;
    logic [2:0] req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic req_ready, resp_valid, resp_err, ram_en, ram_we;
    logic [31:0] resp_rdata, ram_wdata, ram_rdata, wr_data;
    logic [6:0] ram_addr;
    logic [31:0] mem [128];
    int n = 0, bad = 0, en_cnt = 0;
    riscv_lsu_dmem_ctrl #(.AW(7), .DW(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );
    always #5 clk = ~clk;
    // synchronous RAM model plus write/strobe monitors
    always @(posedge clk) begin
        if (ram_en) begin
            en_cnt <= en_cnt + 1;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_data <= ram_wdata;
            end else ram_rdata <= mem[ram_addr];
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic req(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] exp_rd, input logic exp_err);
        int en0;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        en0 = en_cnt;
        @(negedge clk);
        chk({tag, " ready"}, 32'(req_ready), 1);
        chk({tag, " en"}, 32'(ram_en), 32'(!exp_err));
        if (!exp_err) chk({tag, " addr"}, 32'(ram_addr), 32'(a[8:2]));
        @(posedge clk); #1 req_valid = 0;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            chk({tag, " valid"}, 32'(resp_valid), 32'(i == lat));
        end
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
        if (exp_err) chk({tag, " no_ram"}, 32'(en_cnt - en0), 0);
        @(posedge clk); #1;
    endtask
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 0;
        req_valid = 1; req_we = 1; req_funct3 = 2; req_addr = 32'h10; req_wdata = 32'h55;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst en", 32'(ram_en), 0);
        chk("rst valid", 32'(resp_valid), 0);
        chk("rst rdata", resp_rdata, 0);
        chk("rst err", 32'(resp_err), 0);
        chk("rst ready", 32'(req_ready), 1);
        @(posedge clk); #1 rst = 0; req_valid = 0;
        req("sw", 1, 2, 32'h10, 32'hDEADBEEF, 1, 0, 0);
        req("lw", 0, 2, 32'h10, 0, 2, 32'hDEADBEEF, 0);
        req("sb", 1, 0, 32'h11, 32'h000000A5, 2, 0, 0);
        chk("sb word", wr_data, 32'hDEADA5EF);
        req("lb", 0, 0, 32'h11, 0, 2, 32'hFFFFFFA5, 0);
        req("lbu", 0, 4, 32'h11, 0, 2, 32'h000000A5, 0);
        req("sh", 1, 1, 32'h12, 32'h00001234, 2, 0, 0);
        chk("sh word", wr_data, 32'h1234A5EF);
        req("lh", 0, 1, 32'h12, 0, 2, 32'h00001234, 0);
        req("lhu neg", 0, 5, 32'h10, 0, 2, 32'h0000A5EF, 0);
        req("lh neg", 0, 1, 32'h10, 0, 2, 32'hFFFFA5EF, 0);
        req("e lw13", 0, 2, 32'h13, 0, 1, 0, 1);
        req("e lh21", 0, 1, 32'h21, 0, 1, 0, 1);
        req("e lw200", 0, 2, 32'h200, 0, 1, 0, 1);
        req("e f3_3", 0, 3, 32'h20, 0, 1, 0, 1);
        req("e sf3_4", 1, 4, 32'h20, 0, 1, 0, 1);
        // reset during the RMW cycle drops the write
        req_valid = 1; req_we = 1; req_funct3 = 0; req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk); #1 req_valid = 0; rst = 1;
        @(negedge clk);
        chk("rmwrst en", 32'(ram_en), 0);
        chk("rmwrst valid", 32'(resp_valid), 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rmwrst ready", 32'(req_ready), 1);
        chk("rmwrst valid2", 32'(resp_valid), 0);
        @(posedge clk); #1;
        req("rmwrst lw", 0, 2, 32'h10, 0, 2, 32'h1234A5EF, 0);
        // back-to-back: SW, SW, LW, then a held LW waits out the LOAD cycle
        req_valid = 1; req_we = 1; req_funct3 = 2; req_addr = 32'h40; req_wdata = 32'h11111111;
        @(negedge clk); chk("b2b rdy1", 32'(req_ready), 1);
        @(posedge clk); #1 req_addr = 32'h44; req_wdata = 32'h22222222;
        @(negedge clk); chk("b2b v1", 32'(resp_valid), 1); chk("b2b rdy2", 32'(req_ready), 1);
        @(posedge clk); #1 req_we = 0; req_addr = 32'h40;
        @(negedge clk); chk("b2b v2", 32'(resp_valid), 1); chk("b2b rdy3", 32'(req_ready), 1);
        @(posedge clk); #1 req_addr = 32'h44;
        @(negedge clk); chk("b2b load rdy", 32'(req_ready), 0); chk("b2b load v", 32'(resp_valid), 0);
        chk("b2b load en", 32'(ram_en), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("b2b v3", 32'(resp_valid), 1); chk("b2b d3", resp_rdata, 32'h11111111);
        chk("b2b rdy4", 32'(req_ready), 1);
        @(posedge clk); #1 req_valid = 0;
        @(negedge clk); chk("b2b v4a", 32'(resp_valid), 0);
        @(negedge clk); chk("b2b v4", 32'(resp_valid), 1); chk("b2b d4", resp_rdata, 32'h22222222);
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n, bad);
        $finish;
    end
endmodule

// File: doc/riscv_lsu_dmem_ctrl.md
Name: riscv_lsu_dmem_ctrl

Overview:
- Load/store controller between the core's memory stage and the word-wide synchronous data RAM.
- Translates RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW) into word accesses.
- The RAM has no byte enables, so sub-word stores use a read-modify-write sequence.
- Also handles byte-lane extraction, sign/zero extension, and misalignment and range checking.

Parameters:
- AW, 7, RAM word-address width; the RAM holds 2^AW 32-bit words and the byte window is 0 to 2^(AW+2)-1.
- DW, 32, data width; fixed at 32 and not overridable in practice.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or had an illegal funct3.
- ram_en  out  1  to RAM en.
- ram_we  out  1  to RAM we.
- ram_addr  out  AW  to RAM addr; equals req_addr[AW+1:2].
- ram_wdata  out  32  to RAM wdata.
- ram_rdata  in  32  from RAM rdata; valid the cycle after a read is issued.

Behaviour:
- Reset state:
  - FSM in IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - Address/lane/funct3 holding registers cleared.
  - RAM strobes ram_en and ram_we are forced to 0 combinationally while rst=1, including mid-RMW; the pending write is dropped.
- Accept: on a rising edge with req_valid && req_ready. The request fields are captured into holding registers.
- Error check, evaluated in IDLE on the request inputs. Any of the following is an error:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - req_addr[31:AW+2] != 0.
  - Load funct3 in {3,6,7}.
  - Store funct3 > 2.
- Error handling: no RAM access (ram_en=0). At the accept edge, resp_valid<=1, resp_err<=1, resp_rdata<=0. The FSM stays in IDLE.
- Issue path: RAM strobes are combinational from the request in IDLE (ram_en = req_valid && ~error), so the RAM samples on the accept edge.
- States: IDLE, LOAD, RMW.
- IDLE transitions:
  - Load: ram_en=1, ram_we=0; go to LOAD.
  - SW: ram_en=1, ram_we=1, ram_wdata=req_wdata. At the same edge set resp_valid<=1, resp_rdata<=0, resp_err<=0. Stay in IDLE.
  - SB/SH: ram_en=1, ram_we=0 (read the old word); go to RMW.
- LOAD:
  - req_ready=0, ram_en=0.
  - Select the lane from captured addr[1:0]: byte lane k = bits [8k+7:8k]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - On the edge: resp_valid<=1, resp_rdata<=result; go to IDLE.
- RMW:
  - req_ready=0.
  - ram_en=1, ram_we=1, ram_addr = captured address.
  - ram_wdata = ram_rdata with the target lane replaced by captured wdata[7:0] (SB) or wdata[15:0] (SH). Little-endian; all other lanes unchanged.
  - On the edge: resp_valid<=1, resp_rdata<=0; go to IDLE.
- Latency, with the accept edge at N:
  - Error and SW: resp_valid high in cycle N+1.
  - Loads and SB/SH: resp_valid high in cycle N+2.
- Throughput: back-to-back SW and error requests are accepted every cycle. Loads and SB/SH occupy 2 cycles.
- Outputs hold between pulses: resp_valid is 0 in every cycle without a response. resp_rdata and resp_err hold their last value (don't-care when resp_valid=0).
- Store followed by load to the same word: the RAM write lands at the write edge, so the next issued read returns the new data. No forwarding is needed.
- ram_addr and ram_wdata are don't-care when ram_en=0. The bench checks them only when ram_en=1.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> resp_valid in N+1 with err=0; the load returns 0xDEADBEEF in N+2.
- SB 0x11 wdata=0x000000A5 onto word 0xDEADBEEF -> RAM write of 0xDEADA5EF at edge N+1. Then LB 0x11 returns 0xFFFFFFA5 and LBU 0x11 returns 0x000000A5.
- SH 0x12 wdata=0x1234 onto word 0xDEADA5EF -> word becomes 0x1234A5EF. Then LH 0x12 returns 0x00001234.
- Error cases, each with resp_err=1 in N+1, rdata=0, and ram_en never asserted:
  - LW 0x13.
  - LH 0x21.
  - LW 0x200 with AW=7.
  - Load funct3=3.
- Reset in the RMW cycle of an SB -> ram_en=0 that cycle, the word is unchanged on readback, no resp_valid, and req_ready=1 in the next cycle.
- Back-to-back: SW, SW, then LW with req_valid held -> accepted on 3 consecutive edges. During LOAD req_ready=0, and the next request is accepted in the following cycle.
